// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle MUL/MOD sequencer and the ALU decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_MOD = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring remainder.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when to register the outputs.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_mod,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sa,
    input  logic [WIDTH-1:0] sb,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] sa_nxt,
    output logic [WIDTH-1:0] sb_nxt
);

    // The remainder stays below the divisor, so only the shifted trial value
    // needs the extra bit for the compare/subtract.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {acc, sa[WIDTH-1]};
    assign diff  = trial - {1'b0, sb};

    // Select multiply or remainder update; sa shifts left in both modes.
    always_comb begin
        acc_nxt = acc;
        sa_nxt  = sa << 1;
        sb_nxt  = sb;
        if (is_mod) begin
            if (trial >= {1'b0, sb}) begin
                acc_nxt = diff[WIDTH-1:0];
            end else begin
                acc_nxt = trial[WIDTH-1:0];
            end
        end else begin
            if (sb[0]) begin
                acc_nxt = acc + sa;
            end
            sb_nxt = sb >> 1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MOD sequencer beside the single-cycle EX-stage ALU.
// Latency: done WIDTH+1 cycles after accept (1 cycle for MOD by zero).
// Backpressure: stall holds IF/ID/EX from the accept cycle through RUN.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_mod;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sa_nxt;
    logic [WIDTH-1:0] sb_nxt;
    logic             accept;
    logic             sel_op;

    assign sel_op = (alu_ctrl == ALU_MUL) || (alu_ctrl == ALU_MOD);
    // Gated by rst_n so every output reads 0 while reset is held.
    assign accept = rst_n && (state == IDLE) && start && !flush && sel_op;
    assign stall  = accept || (state == RUN);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_mod  (is_mod),
        .acc     (acc),
        .sa      (sa),
        .sb      (sb),
        .acc_nxt (acc_nxt),
        .sa_nxt  (sa_nxt),
        .sb_nxt  (sb_nxt)
    );

    // Sequencer FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_mod      <= 1'b0;
            acc         <= '0;
            sa          <= '0;
            sb          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        is_mod <= (alu_ctrl == ALU_MOD);
                        sa     <= op_a;
                        sb     <= op_b;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        if ((alu_ctrl == ALU_MOD) && (op_b == '0)) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            result      <= op_a;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        sa  <= sa_nxt;
                        sb  <= sb_nxt;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            result      <= acc_nxt;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Leave unconditionally so a start still held for the
                    // finishing instruction is never taken twice.
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'h0;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        d;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and hold start until done, as the stalled pipeline would.
    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ed, input int lat);
        int n;
        bit st_ok;
        bit res_ok;
        @(posedge clk);
        #1;
        start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
        @(negedge clk);
        chk("accept_stall", {63'd0, stall}, 64'd1);
        n = 0; st_ok = 1'b1; res_ok = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            if (!stall || !busy) st_ok = 1'b0;
            if (result !== last_res) res_ok = 1'b0;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("result", {32'd0, result}, {32'd0, er});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, ed});
        chk("done_stall", {63'd0, stall}, 64'd0);
        chk("run_stall_busy", {63'd0, st_ok}, 64'd1);
        chk("result_hold_run", {63'd0, res_ok}, 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("post_busy", {63'd0, busy}, 64'd0);
        chk("post_done", {63'd0, done}, 64'd0);
        chk("post_result", {32'd0, result}, {32'd0, er});
        last_res = er;
    endtask

    initial begin
        bit  no_done;

        tbl[0] = '{3'b010, 32'd7,          32'd6,      32'd42,         1'b0, 33};
        tbl[1] = '{3'b010, 32'hFFFF_FFFF,  32'd2,      32'hFFFF_FFFE,  1'b0, 33};
        tbl[2] = '{3'b011, 32'd100,        32'd7,      32'd2,          1'b0, 33};
        tbl[3] = '{3'b011, 32'd5,          32'd9,      32'd5,          1'b0, 33};
        tbl[4] = '{3'b011, 32'h64,         32'd0,      32'h64,         1'b1, 1};
        tbl[5] = '{3'b010, 32'h0001_0000,  32'h0001_0000, 32'd0,       1'b0, 33};
        tbl[6] = '{3'b011, 32'hFFFF_FFFF,  32'h10,     32'hF,          1'b0, 33};
        tbl[7] = '{3'b010, 32'h1234,       32'h5678,   32'h0626_0060,  1'b0, 33};

        rst_n = 1'b0; start = 1'b0; alu_ctrl = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
        #2;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].d, tbl[i].lat);
        end

        // Non-MUL/MOD controls and start+flush must not be accepted.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            start = 1'b1; op_a = 32'd3; op_b = 32'd4;
            alu_ctrl = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : 3'b010;
            flush = (k == 2);
            @(negedge clk);
            chk("ignore_stall", {63'd0, stall}, 64'd0);
            @(posedge clk);
            #1;
            start = 1'b0; flush = 1'b0;
            @(negedge clk);
            chk("ignore_busy", {63'd0, busy}, 64'd0);
            chk("ignore_done", {63'd0, done}, 64'd0);
        end

        // Flush in RUN cycle 10 aborts without a done pulse.
        @(posedge clk);
        #1;
        start = 1'b1; alu_ctrl = 3'b010; op_a = 32'd7; op_b = 32'd6;
        @(posedge clk);
        for (int i = 0; i < 9; i++) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_stall", {63'd0, stall}, 64'd0);
        chk("flush_result", {32'd0, result}, {32'd0, last_res});
        no_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        chk("flush_no_done", {63'd0, no_done}, 64'd1);
        run_op(3'b011, 32'd17, 32'd5, 32'd2, 1'b0, 33);

        // Reset in RUN cycle 5 clears outputs without waiting for a clock edge.
        @(posedge clk);
        #1;
        start = 1'b1; alu_ctrl = 3'b010; op_a = 32'd7; op_b = 32'd6;
        @(posedge clk);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_stall", {63'd0, stall}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", {32'd0, result}, 64'd0);
        chk("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_res = 32'd0;
        run_op(3'b010, 32'd3, 32'd3, 32'd9, 1'b0, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
